// File: rtl/dist_ram_if.sv
// dist_ram_if
//   Bundle of the tag-table access signals for dist_ram. The RAM keeps flat
//   ports so that a positional 5-port hookup (clk, addr, din, dout, we) still
//   binds. A caller or a bench can use this bundle to carry the signals and
//   wire them to those ports.
//
//   Signals:
//     addr      - word address
//     din       - write data
//     dout      - combinational read data
//     we        - write enable
//     init_done - post-reset clear finished
//   Modports:
//     master - drives addr/din/we, observes dout/init_done
//     slave  - the RAM side
interface dist_ram_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 14
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] din;
  logic [DATA_WIDTH-1:0] dout;
  logic                  we;
  logic                  init_done;

  modport master (
    output addr,
    output din,
    output we,
    input  dout,
    input  init_done
  );

  modport slave (
    input  addr,
    input  din,
    input  we,
    output dout,
    output init_done
  );
endinterface

// File: rtl/dist_ram.sv
// dist_ram
//   Single-port tag table, 2**ADDR_WIDTH x DATA_WIDTH. Reads are asynchronous
//   and writes are synchronous, so the array maps onto distributed LUT RAM.
//   Each word holds {dirty, valid, tag[11:0]} for one cache block. After
//   reset the array sweeps itself to zero, so every line reads back as
//   invalid.
//
//   Ports:
//     clk       in   clock; all state changes happen on the rising edge
//     addr      in   read/write address
//     din       in   write data
//     dout      out  mem[addr], combinational; forced to 0 while clearing
//     we        in   write enable; ignored while clearing
//     rst_n     in   asynchronous active-low reset; starts a full clear
//     init_done out  1 once the clear sweep has finished
module dist_ram #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 14
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  input  logic                  we,
  input  logic                  rst_n,
  output logic                  init_done
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // The declaration values give the power-up image: a zeroed table that is
  // already usable, so a system that never pulses reset still sees every
  // line as invalid.
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

  state_t                state_q     = IDLE;
  state_t                state_d;
  logic [ADDR_WIDTH-1:0] ptr_q       = '0;
  logic [ADDR_WIDTH-1:0] ptr_d;
  logic                  init_done_q = 1'b1;
  logic                  init_done_d;

  // Clear sequencer next state.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    init_done_d = init_done_q;
    if (state_q == CLEAR) begin
      // The pointer wraps back to 0 on the last address, which leaves it
      // ready for the next sweep.
      ptr_d = ptr_q + ADDR_WIDTH'(1);
      if (&ptr_q) begin
        state_d     = IDLE;
        init_done_d = 1'b1;
      end
    end
  end

  // Reset takes effect immediately. Release is sampled on the clock, so the
  // first edge with rst_n high clears address 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= CLEAR;
      ptr_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      init_done_q <= init_done_d;
    end
  end

  // Single write port. The sweep owns it while clearing, and user writes
  // made during that time are dropped rather than queued. Writing 0 to
  // address 0 on edges while reset is held is harmless, because that is the
  // value the sweep leaves there anyway.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem[ptr_q] <= '0;
    end else if (we) begin
      mem[addr] <= din;
    end
  end

  // Asynchronous read. Forcing 0 during the clear makes half-swept contents
  // invisible, so every line reads as valid=0 until the sweep has finished.
  assign dout      = (state_q == CLEAR) ? '0 : mem[addr];
  assign init_done = init_done_q;

endmodule

// File: tb/tb_dist_ram.sv
// tb_dist_ram
//   Directed bench for dist_ram. It checks the power-up image, write/read,
//   read/write collision, the reset clear, a write dropped during the clear,
//   and a reset that arrives mid-sweep.
module tb_dist_ram;

  localparam int AW    = 14;
  localparam int DW    = 14;
  localparam int DEPTH = 1 << AW;

  logic clk;
  logic rst_n;

  dist_ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  dist_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .addr      (bus.addr),
    .din       (bus.din),
    .dout      (bus.dout),
    .we        (bus.we),
    .rst_n     (rst_n),
    .init_done (bus.init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total_cnt = 0;
  int bad_cnt   = 0;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // One edge, then step 1 time unit past it so that inputs change away from
  // the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.addr = a;
    bus.din  = d;
    bus.we   = 1'b1;
    tick();
    bus.we   = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    bus.addr = a;
    #1;
    chk_val(tag, 32'(bus.dout), 32'(exp));
  endtask

  // Count edges after release until init_done rises. The count is capped,
  // so a sequencer that never finishes shows up as a wrong count.
  // Optionally inject a user write at edge 10 to confirm that it is dropped.
  task automatic sweep_count(input bit inject, output int n);
    n = 0;
    while (!bus.init_done && n < DEPTH + 4000) begin
      if (inject && n == 9) begin
        bus.addr = 14'd5;
        bus.din  = 14'h0AAA;
        bus.we   = 1'b1;
      end
      tick();
      n++;
      if (inject && n == 10) bus.we = 1'b0;
      if (inject && n == 100) begin
        bus.addr = 14'h2000;
        #1;
        chk_val("dout_forced_mid_clear", 32'(bus.dout), 32'h0);
      end
    end
  endtask

  int n_edges;

  initial begin
    rst_n    = 1'b1;
    bus.addr = '0;
    bus.din  = '0;
    bus.we   = 1'b0;
    #2;

    // Power-up image without reset.
    chk_val("pwrup_init_done", 32'(bus.init_done), 32'h1);
    rd_chk("pwrup_rd_0000", 14'h0000, 14'h0);
    rd_chk("pwrup_rd_1234", 14'h1234, 14'h0);
    rd_chk("pwrup_rd_3fff", 14'h3FFF, 14'h0);

    // Basic write then read.
    tick();
    wr(14'h0155, 14'h3ABC);
    rd_chk("wr_rd_0155", 14'h0155, 14'h3ABC);
    rd_chk("neighbour_0154", 14'h0154, 14'h0);
    chk_val("init_done_still_1", 32'(bus.init_done), 32'h1);

    // Read/write collision on a held address: old value before the edge,
    // new value after it.
    wr(14'h2000, 14'h1001);
    bus.addr = 14'h2000;
    bus.din  = 14'h2002;
    bus.we   = 1'b1;
    #1;
    chk_val("collide_before", 32'(bus.dout), 32'h1001);
    tick();
    bus.we = 1'b0;
    chk_val("collide_after", 32'(bus.dout), 32'h2002);

    // Back-to-back fill of addresses 0..15, then reset.
    for (int i = 0; i < 16; i++) wr(AW'(i), 14'h3FFF);
    rd_chk("fill_rd_3", 14'd3, 14'h3FFF);
    rst_n = 1'b0;
    #1;
    chk_val("rst_dout_zero", 32'(bus.dout), 32'h0);
    chk_val("rst_init_done_zero", 32'(bus.init_done), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    sweep_count(1'b1, n_edges);
    chk_val("clear_latency", 32'(n_edges), 32'(DEPTH));
    for (int i = 0; i < 16; i++) begin
      bus.addr = AW'(i);
      #1;
      if (bus.dout !== '0 || i == 15)
        chk_val($sformatf("cleared_%0d", i), 32'(bus.dout), 32'h0);
    end
    rd_chk("dropped_wr_addr5", 14'd5, 14'h0);
    rd_chk("cleared_2000", 14'h2000, 14'h0);

    // Reset mid-sweep restarts from address 0.
    wr(14'd8000, 14'h1111);
    wr(14'h3FFF, 14'h1111);
    wr(14'h0000, 14'h1111);
    rd_chk("pre_mid_8000", 14'd8000, 14'h1111);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8000; i++) tick();
    chk_val("mid_sweep_busy", 32'(bus.init_done), 32'h0);
    rst_n = 1'b0;
    #1;
    chk_val("mid_rst_init_done", 32'(bus.init_done), 32'h0);
    tick();
    rst_n = 1'b1;
    sweep_count(1'b0, n_edges);
    chk_val("restart_latency", 32'(n_edges), 32'(DEPTH));
    rd_chk("mid_rd_0000", 14'h0000, 14'h0);
    rd_chk("mid_rd_8000", 14'd8000, 14'h0);
    rd_chk("mid_rd_3fff", 14'h3FFF, 14'h0);

    // The RAM is writable again after the clear.
    wr(14'h3FFF, 14'h2A5A);
    rd_chk("post_clear_wr", 14'h3FFF, 14'h2A5A);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
